// File: rtl/qspi_pkg.sv
// qspi_pkg: shared encodings and frame-length helper for the QSPI FIFO/link glue.
package qspi_pkg;
    typedef enum logic [1:0] {PROTO_SINGLE, PROTO_DUAL, PROTO_QUAD, PROTO_RSVD} proto_e;
    typedef enum logic [1:0] {CS_AUTO, CS_RSVD, CS_HOLD, CS_OFF} cs_e;

    // Lane cycles per frame; wide enough that len+3 never overflows for any LEN_W <= 16.
    function automatic logic [16:0] lane_cnt(input logic [1:0] proto, input logic [15:0] len);
        logic [16:0] l;
        l = {1'b0, len};
        return proto == PROTO_DUAL ? (l + 17'd1) >> 1 :
               proto == PROTO_QUAD ? (l + 17'd3) >> 2 : l;
    endfunction
endpackage

// File: rtl/qspi_sync_fifo.sv
// qspi_sync_fifo: first-word-fall-through synchronous FIFO with flush and occupancy count.
module qspi_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [DATA_W-1:0] enq_bits,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA_W-1:0] deq_bits,
    output logic [CNT_W-1:0]  count
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_enq, do_deq;

    assign enq_ready = count != CNT_W'(DEPTH);
    assign deq_valid = count != '0;
    assign deq_bits = mem[rp];
    assign do_enq = enq_valid & enq_ready;
    assign do_deq = deq_valid & deq_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            wp <= wp + AW'(do_enq);
            rp <= rp + AW'(do_deq);
            count <= count + CNT_W'(do_enq) - CNT_W'(do_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq && !flush) mem[wp] <= enq_bits;
    end
endmodule

// File: rtl/qspi_fifo_ctrl.sv
// qspi_fifo_ctrl: buffers host TX/RX frames and derives link frame length, RX
// tracking and chip-select control from the format/CS registers.
module qspi_fifo_ctrl
    import qspi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH = 8,
    parameter int LEN_W = 4,
    parameter int PEND_W = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        io_ctrl_fmt_proto,
    input  logic              io_ctrl_fmt_endian,
    input  logic              io_ctrl_fmt_iodir,
    input  logic [LEN_W-1:0]  io_ctrl_fmt_len,
    input  logic [1:0]        io_ctrl_cs_mode,
    input  logic [CNT_W-1:0]  io_ctrl_wm_tx,
    input  logic [CNT_W-1:0]  io_ctrl_wm_rx,
    input  logic              io_ctrl_tx_flush,
    input  logic              io_ctrl_rx_flush,
    input  logic              io_ctrl_ovf_clr,
    input  logic              io_link_tx_ready,
    output logic              io_link_tx_valid,
    output logic [DATA_W-1:0] io_link_tx_bits,
    input  logic              io_link_rx_valid,
    input  logic [DATA_W-1:0] io_link_rx_bits,
    output logic [LEN_W-1:0]  io_link_cnt,
    output logic [1:0]        io_link_fmt_proto,
    output logic              io_link_fmt_endian,
    output logic              io_link_fmt_iodir,
    output logic              io_link_cs_set,
    output logic              io_link_cs_clear,
    output logic              io_link_cs_hold,
    input  logic              io_link_active,
    output logic              io_link_lock,
    output logic              io_tx_ready,
    input  logic              io_tx_valid,
    input  logic [DATA_W-1:0] io_tx_bits,
    input  logic              io_rx_ready,
    output logic              io_rx_valid,
    output logic [DATA_W-1:0] io_rx_bits,
    output logic              io_ip_txwm,
    output logic              io_ip_rxwm,
    output logic              io_rx_overflow
);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    logic [CNT_W-1:0] tx_count, rx_count;
    logic [PEND_W-1:0] pend;
    cs_e cs_mode;
    logic fire_tx, inc, dec, rx_enq, rx_enq_ready, unused;

    assign unused = io_link_active;

    qspi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) txq (
        .clk(clock), .rst(reset), .flush(io_ctrl_tx_flush),
        .enq_valid(io_tx_valid), .enq_ready(io_tx_ready), .enq_bits(io_tx_bits),
        .deq_valid(io_link_tx_valid), .deq_ready(io_link_tx_ready), .deq_bits(io_link_tx_bits),
        .count(tx_count)
    );

    qspi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) rxq (
        .clk(clock), .rst(reset), .flush(io_ctrl_rx_flush),
        .enq_valid(rx_enq), .enq_ready(rx_enq_ready), .enq_bits(io_link_rx_bits),
        .deq_valid(io_rx_valid), .deq_ready(io_rx_ready), .deq_bits(io_rx_bits),
        .count(rx_count)
    );

    assign fire_tx = io_link_tx_valid & io_link_tx_ready;
    assign inc = fire_tx & ~io_ctrl_fmt_iodir;
    assign dec = io_link_rx_valid & (pend != '0);
    // Link data only counts as RX when a frame was actually sent expecting a reply.
    assign rx_enq = dec;

    assign io_link_cnt = LEN_W'(lane_cnt(io_ctrl_fmt_proto, 16'(io_ctrl_fmt_len)));
    assign io_link_fmt_proto = io_ctrl_fmt_proto;
    assign io_link_fmt_endian = io_ctrl_fmt_endian;
    assign io_link_fmt_iodir = io_ctrl_fmt_iodir;
    assign io_link_lock = io_link_tx_valid | (pend != '0);
    assign io_link_cs_set = cs_mode != CS_OFF;
    assign io_link_cs_hold = cs_mode == CS_HOLD;
    assign io_link_cs_clear = (cs_mode != cs_e'(io_ctrl_cs_mode)) |
                              (fire_tx & (cs_mode == CS_AUTO || cs_mode == CS_RSVD));
    assign io_ip_txwm = tx_count < io_ctrl_wm_tx;
    assign io_ip_rxwm = rx_count > io_ctrl_wm_rx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend <= '0;
            cs_mode <= CS_AUTO;
            io_rx_overflow <= 1'b0;
        end else begin
            cs_mode <= cs_e'(io_ctrl_cs_mode);
            if (inc && !dec && pend != PEND_MAX) pend <= pend + PEND_W'(1);
            else if (dec && !inc) pend <= pend - PEND_W'(1);
            if (rx_enq && !rx_enq_ready) io_rx_overflow <= 1'b1;
            else if (io_ctrl_ovf_clr) io_rx_overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_qspi_fifo_ctrl.sv
// tb_qspi_fifo_ctrl: scoreboard bench for qspi_fifo_ctrl with default parameters.
module tb_qspi_fifo_ctrl;
    logic clock = 0, reset = 1;
    logic [1:0] io_ctrl_fmt_proto = 0, io_ctrl_cs_mode = 0, io_link_fmt_proto;
    logic io_ctrl_fmt_endian = 0, io_ctrl_fmt_iodir = 1;
    logic [3:0] io_ctrl_fmt_len = 0, io_ctrl_wm_tx = 2, io_ctrl_wm_rx = 0, io_link_cnt;
    logic io_ctrl_tx_flush = 0, io_ctrl_rx_flush = 0, io_ctrl_ovf_clr = 0;
    logic io_link_tx_ready = 0, io_link_tx_valid, io_link_rx_valid = 0;
    logic [7:0] io_link_tx_bits, io_link_rx_bits = 0, io_tx_bits = 0, io_rx_bits;
    logic io_link_fmt_endian, io_link_fmt_iodir, io_link_cs_set, io_link_cs_clear, io_link_cs_hold;
    logic io_link_active = 0, io_link_lock, io_tx_ready, io_tx_valid = 0, io_rx_ready = 0, io_rx_valid;
    logic io_ip_txwm, io_ip_rxwm, io_rx_overflow;
    int n_tests = 0, n_fail = 0;
    logic [7:0] txq[$], rxq[$];

    qspi_fifo_ctrl dut (
        .clock(clock), .reset(reset),
        .io_ctrl_fmt_proto(io_ctrl_fmt_proto), .io_ctrl_fmt_endian(io_ctrl_fmt_endian),
        .io_ctrl_fmt_iodir(io_ctrl_fmt_iodir), .io_ctrl_fmt_len(io_ctrl_fmt_len),
        .io_ctrl_cs_mode(io_ctrl_cs_mode), .io_ctrl_wm_tx(io_ctrl_wm_tx), .io_ctrl_wm_rx(io_ctrl_wm_rx),
        .io_ctrl_tx_flush(io_ctrl_tx_flush), .io_ctrl_rx_flush(io_ctrl_rx_flush),
        .io_ctrl_ovf_clr(io_ctrl_ovf_clr),
        .io_link_tx_ready(io_link_tx_ready), .io_link_tx_valid(io_link_tx_valid),
        .io_link_tx_bits(io_link_tx_bits), .io_link_rx_valid(io_link_rx_valid),
        .io_link_rx_bits(io_link_rx_bits), .io_link_cnt(io_link_cnt),
        .io_link_fmt_proto(io_link_fmt_proto), .io_link_fmt_endian(io_link_fmt_endian),
        .io_link_fmt_iodir(io_link_fmt_iodir), .io_link_cs_set(io_link_cs_set),
        .io_link_cs_clear(io_link_cs_clear), .io_link_cs_hold(io_link_cs_hold),
        .io_link_active(io_link_active), .io_link_lock(io_link_lock),
        .io_tx_ready(io_tx_ready), .io_tx_valid(io_tx_valid), .io_tx_bits(io_tx_bits),
        .io_rx_ready(io_rx_ready), .io_rx_valid(io_rx_valid), .io_rx_bits(io_rx_bits),
        .io_ip_txwm(io_ip_txwm), .io_ip_rxwm(io_ip_rxwm), .io_rx_overflow(io_rx_overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        io_tx_valid = 1;
        io_tx_bits = b;
        if (io_tx_ready) txq.push_back(b);
        tick;
        io_tx_valid = 0;
    endtask

    task automatic link_rx(input logic [7:0] b, input bit enq);
        io_link_rx_valid = 1;
        io_link_rx_bits = b;
        if (enq) rxq.push_back(b);
        tick;
        io_link_rx_valid = 0;
    endtask

    // Scoreboard side: compare whatever the DUT hands out, mid-cycle.
    always @(negedge clock) begin
        if (!reset && io_link_tx_valid && io_link_tx_ready) begin
            if (txq.size() == 0) check("tx_unexpected", io_link_tx_bits, 32'hFFFF_FFFF);
            else check("tx_data", io_link_tx_bits, txq.pop_front());
        end
        if (!reset && io_rx_valid && io_rx_ready) begin
            if (rxq.size() == 0) check("rx_unexpected", io_rx_bits, 32'hFFFF_FFFF);
            else check("rx_data", io_rx_bits, rxq.pop_front());
        end
    end

    initial begin
        logic [3:0] lens[4] = '{4'd5, 4'd8, 4'd0, 4'd7};
        logic [1:0] protos[4] = '{2'd2, 2'd1, 2'd0, 2'd3};
        logic [3:0] cnts[4] = '{4'd2, 4'd4, 4'd0, 4'd7};
        tick;
        tick;
        check("rst_tx_valid", io_link_tx_valid, 0);
        check("rst_rx_valid", io_rx_valid, 0);
        check("rst_tx_ready", io_tx_ready, 1);
        check("rst_lock", io_link_lock, 0);
        check("rst_cs_set", io_link_cs_set, 1);
        check("rst_cs_hold", io_link_cs_hold, 0);
        check("rst_txwm", io_ip_txwm, 1);
        check("rst_rxwm", io_ip_rxwm, 0);
        check("rst_ovf", io_rx_overflow, 0);
        reset = 0;
        tick;

        // Fill TX with the link stalled, then full-FIFO enq+deq, then drain.
        for (int i = 0; i < 8; i++) begin
            push_tx(8'h30 + 8'(i));
            check("fill_tx_ready", io_tx_ready, i < 7);
        end
        check("full_txwm", io_ip_txwm, 0);
        io_tx_valid = 1;
        io_tx_bits = 8'hEE;
        io_link_tx_ready = 1;
        check("full_enq_ready", io_tx_ready, 0);
        tick;
        io_tx_valid = 0;
        check("after_deq_ready", io_tx_ready, 1);
        for (int c = 7; c > 0; c--) begin
            check("drain_txwm", io_ip_txwm, c < 2);
            tick;
        end
        check("drained_txwm", io_ip_txwm, 1);
        check("drained_tx_valid", io_link_tx_valid, 0);
        io_link_tx_ready = 0;
        check("txq_empty", txq.size(), 0);

        for (int i = 0; i < 4; i++) begin
            io_ctrl_fmt_proto = protos[i];
            io_ctrl_fmt_len = lens[i];
            #1;
            check("link_cnt", io_link_cnt, cnts[i]);
        end
        io_ctrl_fmt_proto = 0;

        // Pending RX tracking: four fires saturate at 3.
        io_ctrl_fmt_iodir = 0;
        for (int i = 0; i < 4; i++) push_tx(8'h50 + 8'(i));
        io_link_tx_ready = 1;
        repeat (4) tick;
        io_link_tx_ready = 0;
        check("sat_lock", io_link_lock, 1);
        check("sat_tx_valid", io_link_tx_valid, 0);
        link_rx(8'h10, 1);
        link_rx(8'h11, 1);
        check("pend1_lock", io_link_lock, 1);
        link_rx(8'h12, 1);
        check("pend0_lock", io_link_lock, 0);
        io_ctrl_wm_rx = 3;
        link_rx(8'h13, 0);
        check("ignored_rx_rxwm", io_ip_rxwm, 0);
        io_rx_ready = 1;
        repeat (3) tick;
        io_rx_ready = 0;
        check("rx_drained_valid", io_rx_valid, 0);
        check("rxq_empty_a", rxq.size(), 0);

        // Overflow: nine fire/rx pairs into an 8-deep RX FIFO.
        io_link_tx_ready = 1;
        for (int i = 0; i < 9; i++) begin
            push_tx(8'h70 + 8'(i));
            tick;
            if (i == 8) check("pre_ovf", io_rx_overflow, 0);
            link_rx(8'hA0 + 8'(i), i < 8);
        end
        check("ovf_set", io_rx_overflow, 1);
        push_tx(8'h7F);
        tick;
        io_link_rx_valid = 1;
        io_link_rx_bits = 8'hBB;
        io_ctrl_ovf_clr = 1;
        tick;
        io_link_rx_valid = 0;
        check("ovf_set_wins", io_rx_overflow, 1);
        tick;
        io_ctrl_ovf_clr = 0;
        check("ovf_clr", io_rx_overflow, 0);
        io_ctrl_wm_rx = 7;
        #1;
        check("full_rxwm", io_ip_rxwm, 1);
        io_rx_ready = 1;
        repeat (8) tick;
        io_rx_ready = 0;
        check("rxq_empty_b", rxq.size(), 0);
        check("rx_empty_valid", io_rx_valid, 0);

        // Chip-select control.
        io_ctrl_fmt_iodir = 1;
        io_ctrl_cs_mode = 2;
        #1;
        check("cs_change_clear", io_link_cs_clear, 1);
        check("cs_pre_hold", io_link_cs_hold, 0);
        tick;
        check("cs_hold_clear", io_link_cs_clear, 0);
        check("cs_hold", io_link_cs_hold, 1);
        check("cs_hold_set", io_link_cs_set, 1);
        push_tx(8'hC1);
        check("hold_fire_valid", io_link_tx_valid, 1);
        check("hold_fire_clear", io_link_cs_clear, 0);
        tick;
        io_ctrl_cs_mode = 0;
        tick;
        push_tx(8'hC2);
        check("auto_fire_clear", io_link_cs_clear, 1);
        tick;
        io_ctrl_cs_mode = 3;
        tick;
        check("cs_off_set", io_link_cs_set, 0);
        check("cs_off_hold", io_link_cs_hold, 0);
        io_ctrl_cs_mode = 0;
        tick;

        // TX flush with a simultaneous enqueue.
        io_link_tx_ready = 0;
        io_ctrl_wm_tx = 1;
        for (int i = 0; i < 5; i++) push_tx(8'hD0 + 8'(i));
        check("pre_flush_txwm", io_ip_txwm, 0);
        io_tx_valid = 1;
        io_tx_bits = 8'h77;
        io_ctrl_tx_flush = 1;
        tick;
        io_tx_valid = 0;
        io_ctrl_tx_flush = 0;
        txq.delete();
        check("flush_tx_valid", io_link_tx_valid, 0);
        check("flush_txwm", io_ip_txwm, 1);
        push_tx(8'h5A);
        io_link_tx_ready = 1;
        tick;
        io_link_tx_ready = 0;
        check("txq_empty_c", txq.size(), 0);

        // Reset mid-operation with a pending frame and queued TX data.
        io_ctrl_fmt_iodir = 0;
        push_tx(8'h61);
        io_link_tx_ready = 1;
        tick;
        io_link_tx_ready = 0;
        push_tx(8'h62);
        push_tx(8'h63);
        io_ctrl_cs_mode = 2;
        tick;
        check("pre_rst_lock", io_link_lock, 1);
        #3 reset = 1;
        #1;
        txq.delete();
        rxq.delete();
        check("mid_rst_tx_valid", io_link_tx_valid, 0);
        check("mid_rst_lock", io_link_lock, 0);
        check("mid_rst_tx_ready", io_tx_ready, 1);
        check("mid_rst_cs_hold", io_link_cs_hold, 0);
        check("mid_rst_cs_set", io_link_cs_set, 1);
        check("mid_rst_txwm", io_ip_txwm, 1);
        io_ctrl_cs_mode = 0;
        tick;
        reset = 0;
        tick;
        check("post_rst_lock", io_link_lock, 0);
        check("post_rst_rx_valid", io_rx_valid, 0);
        tick;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
